// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one full-subtractor cell with a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Bout,
    output logic             Ovf
`else
    output logic             Bout
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             br, a, b, d, bo, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             am, bm;
`endif

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        a       = sa[0];
        b       = sb[0];
        d       = a ^ b ^ br;
        bo      = (~a & b) | (~(a ^ b) & br);
        res_nxt = {d, res[WIDTH-1:1]};
        last    = cnt == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am    <= 1'b0;
            bm    <= 1'b0;
            Ovf   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            state <= SHIFT;
            sa    <= A;
            sb    <= B;
            br    <= Bin;
            cnt   <= '0;
            res   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            am    <= A[WIDTH-1];
            bm    <= B[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= bo;
            cnt <= cnt + 1'b1;
            res <= res_nxt;
            if (last) begin
                state <= DONE;
                Diff  <= res_nxt;
                Bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
                // d is the result MSB on the final step
                Ovf   <= (am != bm) & (d != am);
`endif
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule
